// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings, FSM states and win-line masks for the tic-tac-toe controller
package ttt_pkg;
  localparam int CELLS = 9;
  typedef enum logic [2:0] {X_TURN, O_TURN, X_WIN, O_WIN, DRAW} status_t;
  typedef enum logic [2:0] {WAIT_HUMAN, EVAL, AI_WAIT, AI_COMMIT, DONE} state_t;
  localparam logic [7:0][CELLS-1:0] WIN_LINES = {
    9'h007, 9'h038, 9'h1c0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };
endpackage

// File: rtl/ttt_turn_controller_if.sv
// ttt_turn_controller_if: move inputs, AI suggestion and board/status outputs of the controller
interface ttt_turn_controller_if;
  logic       tick;
  logic       move_req;
  logic [3:0] move_sel;
  logic       ai_enable;
  logic [8:0] ai_move;
  logic [8:0] x_state;
  logic [8:0] o_state;
  logic [2:0] game_status;
  logic       illegal;
  logic       ai_busy;
  modport master (output tick, move_req, move_sel, ai_enable, ai_move,
                  input x_state, o_state, game_status, illegal, ai_busy);
  modport slave (input tick, move_req, move_sel, ai_enable, ai_move,
                 output x_state, o_state, game_status, illegal, ai_busy);
endinterface

// File: rtl/ttt_line_check.sv
// ttt_line_check: flags a completed line and a fully occupied vector
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [CELLS-1:0] occ,
  output logic             win,
  output logic             full
);
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) win = win | ((occ & WIN_LINES[i]) == WIN_LINES[i]);
  end
  assign full = &occ;
endmodule

// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller: sequences one game, validates human moves, commits AI moves, detects win/draw
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int AI_DELAY = 4,
  parameter int CNT_W    = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  ttt_turn_controller_if.slave bus
);
  state_t             state_q, state_d;
  status_t            status_q, status_d;
  logic [CELLS-1:0]   x_q, x_d, o_q, o_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic [CELLS-1:0]   occ, free, low_free, sel_hot, ai_pick, mover;
  logic               legal, accept, win, unused_full;
  assign occ      = x_q | o_q;
  assign free     = ~occ;
  assign low_free = free & (~free + 9'd1);
  assign sel_hot  = 9'd1 << bus.move_sel;
  assign legal    = (bus.move_sel <= 4'd8) && ((occ & sel_hot) == '0);
  // an O_TURN with the AI switched on belongs to the AI, so the button is ignored
  assign accept   = bus.move_req && !(status_q == O_TURN && bus.ai_enable);
  assign ai_pick  = ($onehot(bus.ai_move) && ((bus.ai_move & occ) == '0)) ? bus.ai_move : low_free;
  assign mover    = (status_q == O_TURN) ? o_q : x_q;
  ttt_line_check u_line_check (.occ(mover), .win(win), .full(unused_full));
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    x_d       = x_q;
    o_d       = o_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      WAIT_HUMAN: if (accept) begin
        if (!legal) illegal_d = 1'b1;
        else begin
          x_d     = (status_q == X_TURN) ? (x_q | sel_hot) : x_q;
          o_d     = (status_q == O_TURN) ? (o_q | sel_hot) : o_q;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (win) begin
          status_d = (status_q == X_TURN) ? X_WIN : O_WIN;
          state_d  = DONE;
        end else if (&occ) begin
          status_d = DRAW;
          state_d  = DONE;
        end else begin
          status_d = (status_q == X_TURN) ? O_TURN : X_TURN;
          state_d  = (status_q == X_TURN && bus.ai_enable) ? AI_WAIT : WAIT_HUMAN;
          cnt_d    = '0;
        end
      end
      AI_WAIT: if (bus.tick) begin
        if (cnt_q == CNT_W'(AI_DELAY - 1)) state_d = AI_COMMIT;
        else cnt_d = cnt_q + 1'b1;
      end
      AI_COMMIT: begin
        o_d     = o_q | ai_pick;
        state_d = EVAL;
      end
      DONE: state_d = DONE;
      default: state_d = WAIT_HUMAN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HUMAN;
      status_q  <= X_TURN;
      x_q       <= '0;
      o_q       <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      x_q       <= x_d;
      o_q       <= o_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.x_state     = x_q;
  assign bus.o_state     = o_q;
  assign bus.game_status = status_q;
  assign bus.illegal     = illegal_q;
  assign bus.ai_busy     = (state_q == AI_WAIT) || (state_q == AI_COMMIT);
endmodule

// File: tb/tb_ttt_turn_controller.sv
// tb_ttt_turn_controller: directed game scenarios checked against a queue of expected boards
module tb_ttt_turn_controller;
  typedef struct {
    string      tag;
    logic [8:0] x;
    logic [8:0] o;
    logic [2:0] st;
    logic       ill;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int ticks;
  exp_t sb[$];
  ttt_turn_controller_if bus();
  ttt_turn_controller #(.AI_DELAY(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pop_board();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".x"}, 32'(bus.x_state), 32'(e.x));
    chk({e.tag, ".o"}, 32'(bus.o_state), 32'(e.o));
    chk({e.tag, ".status"}, 32'(bus.game_status), 32'(e.st));
  endtask
  task automatic human(input string tag, input logic [3:0] sel, input logic [8:0] ex,
                       input logic [8:0] eo, input logic [2:0] es, input logic ill);
    logic ill_seen;
    sb.push_back('{tag, ex, eo, es, ill});
    bus.move_sel = sel;
    bus.move_req = 1'b1;
    @(negedge clk);
    bus.move_req = 1'b0;
    ill_seen = bus.illegal;
    @(negedge clk);
    chk({tag, ".illegal"}, 32'(ill_seen), 32'(ill));
    chk({tag, ".illegal_end"}, 32'(bus.illegal), 32'(0));
    pop_board();
  endtask
  task automatic ai_run(output int n);
    n = 0;
    while (bus.ai_busy && n < 20) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      n++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ".x"}, 32'(bus.x_state), 32'(0));
    chk({tag, ".o"}, 32'(bus.o_state), 32'(0));
    chk({tag, ".status"}, 32'(bus.game_status), 32'(0));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(0));
    chk({tag, ".busy"}, 32'(bus.ai_busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.move_req = 1'b0;
    bus.move_sel = 4'd0;
    bus.ai_enable = 1'b0;
    bus.ai_move = 9'h000;
    @(negedge clk);
    do_reset("rst0");
    human("xwin_x0", 4'd0, 9'h001, 9'h000, 3'd1, 1'b0);
    human("xwin_o3", 4'd3, 9'h001, 9'h008, 3'd0, 1'b0);
    human("xwin_x1", 4'd1, 9'h003, 9'h008, 3'd1, 1'b0);
    human("xwin_o4", 4'd4, 9'h003, 9'h018, 3'd0, 1'b0);
    human("xwin_x2", 4'd2, 9'h007, 9'h018, 3'd2, 1'b0);
    human("done_ignored", 4'd5, 9'h007, 9'h018, 3'd2, 1'b0);
    do_reset("rst1");
    human("ill_x4", 4'd4, 9'h010, 9'h000, 3'd1, 1'b0);
    human("ill_dup4", 4'd4, 9'h010, 9'h000, 3'd1, 1'b1);
    human("ill_sel9", 4'd9, 9'h010, 9'h000, 3'd1, 1'b1);
    human("ill_o5", 4'd5, 9'h010, 9'h020, 3'd0, 1'b0);
    do_reset("rst2");
    bus.ai_enable = 1'b1;
    bus.ai_move = 9'h010;
    human("ai_x0", 4'd0, 9'h001, 9'h000, 3'd1, 1'b0);
    chk("ai_busy_start", 32'(bus.ai_busy), 32'(1));
    sb.push_back('{"ai_commit", 9'h001, 9'h010, 3'd0, 1'b0});
    ai_run(ticks);
    chk("ai_tick_count", 32'(ticks), 32'(4));
    chk("ai_busy_end", 32'(bus.ai_busy), 32'(0));
    pop_board();
    do_reset("rst3");
    bus.ai_move = 9'h001;
    human("fb_x0", 4'd0, 9'h001, 9'h000, 3'd1, 1'b0);
    sb.push_back('{"fb_commit", 9'h001, 9'h002, 3'd0, 1'b0});
    ai_run(ticks);
    chk("fb_tick_count", 32'(ticks), 32'(4));
    pop_board();
    bus.ai_move = 9'h003;
    human("fb2_x4", 4'd4, 9'h011, 9'h002, 3'd1, 1'b0);
    sb.push_back('{"fb2_commit", 9'h011, 9'h006, 3'd0, 1'b0});
    ai_run(ticks);
    pop_board();
    do_reset("rst4");
    bus.ai_enable = 1'b0;
    human("draw_x0", 4'd0, 9'h001, 9'h000, 3'd1, 1'b0);
    human("draw_o1", 4'd1, 9'h001, 9'h002, 3'd0, 1'b0);
    human("draw_x2", 4'd2, 9'h005, 9'h002, 3'd1, 1'b0);
    human("draw_o4", 4'd4, 9'h005, 9'h012, 3'd0, 1'b0);
    human("draw_x3", 4'd3, 9'h00d, 9'h012, 3'd1, 1'b0);
    human("draw_o5", 4'd5, 9'h00d, 9'h032, 3'd0, 1'b0);
    human("draw_x7", 4'd7, 9'h08d, 9'h032, 3'd1, 1'b0);
    human("draw_o6", 4'd6, 9'h08d, 9'h072, 3'd0, 1'b0);
    human("draw_x8", 4'd8, 9'h18d, 9'h072, 3'd4, 1'b0);
    do_reset("rst5");
    human("w9_x0", 4'd0, 9'h001, 9'h000, 3'd1, 1'b0);
    human("w9_o1", 4'd1, 9'h001, 9'h002, 3'd0, 1'b0);
    human("w9_x2", 4'd2, 9'h005, 9'h002, 3'd1, 1'b0);
    human("w9_o4", 4'd4, 9'h005, 9'h012, 3'd0, 1'b0);
    human("w9_x3", 4'd3, 9'h00d, 9'h012, 3'd1, 1'b0);
    human("w9_o5", 4'd5, 9'h00d, 9'h032, 3'd0, 1'b0);
    human("w9_x7", 4'd7, 9'h08d, 9'h032, 3'd1, 1'b0);
    human("w9_o8", 4'd8, 9'h08d, 9'h132, 3'd0, 1'b0);
    human("w9_x6", 4'd6, 9'h0cd, 9'h132, 3'd2, 1'b0);
    do_reset("rst6");
    bus.ai_enable = 1'b1;
    bus.ai_move = 9'h010;
    human("abort_x0", 4'd0, 9'h001, 9'h000, 3'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      @(negedge clk);
    end
    chk("abort_busy_before", 32'(bus.ai_busy), 32'(1));
    do_reset("abort_rst");
    for (int i = 0; i < 8; i++) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      @(negedge clk);
    end
    sb.push_back('{"abort_after", 9'h000, 9'h000, 3'd0, 1'b0});
    pop_board();
    chk("abort_busy_after", 32'(bus.ai_busy), 32'(0));
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
